// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the image loader.
// The slave side is the loader; the master side is the host plus memory.
interface imem_loader_if #(
   parameter int ADDR_W = 4,
   parameter int WORD_W = 16
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WORD_W-1:0] wr_data;

   modport master (
      output in_valid, in_data,
      input  in_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/imem_loader.sv
// Assembles a LEN / N words / CSUM byte stream into 16-bit instruction writes
// and keeps the CPU stalled until a complete image passes its XOR checksum.
module imem_loader #(
   parameter int ADDR_W = 4,
   parameter int WORD_W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   imem_loader_if.slave  bus,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_HI,
      S_LO,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [7:0]    MAX_LEN = 8'(1 << ADDR_W);
   localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

   state_t            state;
   logic [7:0]        acc;
   logic [7:0]        hi_reg;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic              in_ready_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [WORD_W-1:0] wr_data_q;
   logic              accept;

   assign accept       = bus.in_valid & in_ready_q;
   assign bus.in_ready = in_ready_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         acc        <= '0;
         hi_reg     <= '0;
         addr       <= '0;
         remaining  <= '0;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_LEN;
                  acc        <= '0;
                  addr       <= '0;
                  cpu_hold   <= 1'b1;
                  in_ready_q <= 1'b1;
               end
            end

            S_LEN: begin
               if (accept) begin
                  acc <= bus.in_data;
                  if (bus.in_data == 8'd0 || bus.in_data > MAX_LEN) begin
                     state      <= S_ERR;
                     err        <= 1'b1;
                     cpu_hold   <= 1'b1;
                     in_ready_q <= 1'b0;
                  end else begin
                     remaining <= bus.in_data[ADDR_W:0];
                     state     <= S_HI;
                  end
               end
            end

            S_HI: begin
               if (accept) begin
                  hi_reg <= bus.in_data;
                  acc    <= acc ^ bus.in_data;
                  state  <= S_LO;
               end
            end

            S_LO: begin
               if (accept) begin
                  acc       <= acc ^ bus.in_data;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= addr;
                  wr_data_q <= {hi_reg, bus.in_data};
                  remaining <= remaining - ONE;
                  // addr holds on the last word so a full-depth image never wraps
                  if (remaining == ONE) begin
                     state <= S_CSUM;
                  end else begin
                     addr  <= addr + 1'b1;
                     state <= S_HI;
                  end
               end
            end

            S_CSUM: begin
               if (accept) begin
                  in_ready_q <= 1'b0;
                  if (bus.in_data == acc) begin
                     state    <= S_DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     state    <= S_ERR;
                     err      <= 1'b1;
                     cpu_hold <= 1'b1;
                  end
               end
            end

            S_DONE, S_ERR: begin
               if (start) begin
                  state      <= S_LEN;
                  done       <= 1'b0;
                  err        <= 1'b0;
                  cpu_hold   <= 1'b1;
                  acc        <= '0;
                  addr       <= '0;
                  in_ready_q <= 1'b1;
               end
            end

            default: begin
               state      <= S_IDLE;
               in_ready_q <= 1'b0;
               cpu_hold   <= 1'b1;
            end
         endcase
      end
   end

endmodule
